tsn_md_queue_buf: RTL and testbench

- Metadata buffer (MB) directly upstream of the priority scheduler in the TSN egress path.
- Holds 8-bit packet metadata in four per-priority FIFO queues (q0 highest) and reports per-queue non-empty status to gate control (GC).
- Pops one entry per scheduler read-enable and forwards it as a registered md/md_wr pair to the scheduler.
- Counts metadata dropped on full queues.

---
 rtl/tsn_md_queue_buf.sv | 102 ++++++++++
 tb/tb_tsn_md_queue_buf.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tsn_md_queue_buf.sv
// Per-priority metadata buffer feeding the TSN egress scheduler: four FIFO queues
// (q0 highest priority), a registered single-entry pop path and a saturating drop counter.
module tsn_md_queue_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_mb_md,
    input  logic        in_mb_md_wr,
    input  logic [1:0]  in_mb_qid,
    input  logic        in_mb_q0_rden,
    input  logic        in_mb_q1_rden,
    input  logic        in_mb_q2_rden,
    input  logic        in_mb_q3_rden,
    output logic [3:0]  out_mb_q_nempty,
    output logic [3:0]  out_mb_q_full,
    output logic [7:0]  out_mb_md,
    output logic        out_mb_md_wr,
    output logic        out_mb_drop,
    output logic [15:0] out_mb_drop_cnt
);

    // Handshake: the write side has no ready; in_mb_md_wr is accepted whenever the target
    // queue is below DEPTH, otherwise it is dropped. On the read side rden is a request and
    // out_mb_md_wr is the valid strobe for out_mb_md, exactly one cycle after the pop edge.
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [4][DEPTH];
    logic [AW-1:0] wr_ptr [4];
    logic [AW-1:0] rd_ptr [4];
    logic [AW:0]   cnt [4];
    logic [AW:0]   cnt_nxt [4];

    logic [3:0] rden;
    logic [1:0] pop_sel;
    logic       pop_ok;
    logic       wr_ok;
    logic       wr_drop;

    assign rden = {in_mb_q3_rden, in_mb_q2_rden, in_mb_q1_rden, in_mb_q0_rden};

    // Only the highest asserted request is considered; an empty winner pops nothing.
    always_comb begin
        pop_sel = 2'd3;
        if (rden[0])      pop_sel = 2'd0;
        else if (rden[1]) pop_sel = 2'd1;
        else if (rden[2]) pop_sel = 2'd2;
        pop_ok  = (|rden) && (cnt[pop_sel] != '0);
        wr_ok   = in_mb_md_wr && (cnt[in_mb_qid] != FULL_CNT);
        wr_drop = in_mb_md_wr && (cnt[in_mb_qid] == FULL_CNT);
        for (int i = 0; i < 4; i++) begin
            cnt_nxt[i] = cnt[i];
            if (wr_ok && (in_mb_qid == 2'(i)))
                cnt_nxt[i] = cnt_nxt[i] + (AW + 1)'(1);
            if (pop_ok && (pop_sel == 2'(i)))
                cnt_nxt[i] = cnt_nxt[i] - (AW + 1)'(1);
        end
    end

    // Storage carries no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[in_mb_qid][wr_ptr[in_mb_qid]] <= in_mb_md;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            out_mb_q_nempty <= 4'd0;
            out_mb_q_full   <= 4'd0;
            out_mb_md       <= 8'd0;
            out_mb_md_wr    <= 1'b0;
            out_mb_drop     <= 1'b0;
            out_mb_drop_cnt <= 16'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt[i]             <= cnt_nxt[i];
                out_mb_q_nempty[i] <= (cnt_nxt[i] != '0);
                out_mb_q_full[i]   <= (cnt_nxt[i] == FULL_CNT);
            end
            if (wr_ok)
                wr_ptr[in_mb_qid] <= wr_ptr[in_mb_qid] + AW'(1);
            if (pop_ok) begin
                rd_ptr[pop_sel] <= rd_ptr[pop_sel] + AW'(1);
                out_mb_md       <= mem[pop_sel][rd_ptr[pop_sel]];
                out_mb_md_wr    <= 1'b1;
            end else begin
                out_mb_md       <= 8'd0;
                out_mb_md_wr    <= 1'b0;
            end
            out_mb_drop <= wr_drop;
            if (wr_drop && (out_mb_drop_cnt != 16'hFFFF))
                out_mb_drop_cnt <= out_mb_drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_tsn_md_queue_buf.sv
// Bench for tsn_md_queue_buf: directed scenarios plus random traffic against a
// queue-based reference model of the four priority FIFOs.
module tb_tsn_md_queue_buf;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_mb_md;
    logic        in_mb_md_wr;
    logic [1:0]  in_mb_qid;
    logic        in_mb_q0_rden, in_mb_q1_rden, in_mb_q2_rden, in_mb_q3_rden;
    logic [3:0]  out_mb_q_nempty;
    logic [3:0]  out_mb_q_full;
    logic [7:0]  out_mb_md;
    logic        out_mb_md_wr;
    logic        out_mb_drop;
    logic [15:0] out_mb_drop_cnt;

    tsn_md_queue_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_mb_md        (in_mb_md),
        .in_mb_md_wr     (in_mb_md_wr),
        .in_mb_qid       (in_mb_qid),
        .in_mb_q0_rden   (in_mb_q0_rden),
        .in_mb_q1_rden   (in_mb_q1_rden),
        .in_mb_q2_rden   (in_mb_q2_rden),
        .in_mb_q3_rden   (in_mb_q3_rden),
        .out_mb_q_nempty (out_mb_q_nempty),
        .out_mb_q_full   (out_mb_q_full),
        .out_mb_md       (out_mb_md),
        .out_mb_md_wr    (out_mb_md_wr),
        .out_mb_drop     (out_mb_drop),
        .out_mb_drop_cnt (out_mb_drop_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [7:0]  mq [4][$];
    logic [7:0]  exp_q [$];
    logic [15:0] m_drop_cnt;
    logic        e_md_wr, e_drop;
    logic [3:0]  e_nempty, e_full;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        exp_q.delete();
        m_drop_cnt = 16'd0;
        e_md_wr = 1'b0; e_drop = 1'b0; e_nempty = 4'd0; e_full = 4'd0;
    endtask

    // One clock of the spec's rules: full test and pop both use the pre-edge occupancy.
    task automatic model_step(input logic wr, input logic [1:0] qid, input logic [7:0] md,
                              input logic [3:0] rd);
        bit full_pre;
        int sel;
        full_pre = (mq[qid].size() == DEPTH);
        sel = -1;
        for (int i = 3; i >= 0; i--) if (rd[i]) sel = i;
        e_md_wr = 1'b0;
        if (sel >= 0 && mq[sel].size() > 0) begin
            exp_q.push_back(mq[sel].pop_front());
            e_md_wr = 1'b1;
        end
        e_drop = 1'b0;
        if (wr) begin
            if (full_pre) begin
                e_drop = 1'b1;
                if (m_drop_cnt != 16'hFFFF) m_drop_cnt = m_drop_cnt + 16'd1;
            end else begin
                mq[qid].push_back(md);
            end
        end
        for (int i = 0; i < 4; i++) begin
            e_nempty[i] = (mq[i].size() != 0);
            e_full[i]   = (mq[i].size() == DEPTH);
        end
    endtask

    task automatic check_outputs();
        check("md_wr", out_mb_md_wr, e_md_wr);
        if (out_mb_md_wr) begin
            if (exp_q.size() == 0) check("md_unexpected", 1, 0);
            else                   check("md", out_mb_md, exp_q.pop_front());
        end else begin
            check("md_idle", out_mb_md, 0);
        end
        check("nempty", out_mb_q_nempty, e_nempty);
        check("full", out_mb_q_full, e_full);
        check("drop", out_mb_drop, e_drop);
        check("drop_cnt", out_mb_drop_cnt, m_drop_cnt);
    endtask

    task automatic drive(input logic wr, input logic [1:0] qid, input logic [7:0] md,
                         input logic [3:0] rd);
        in_mb_md_wr = wr; in_mb_qid = qid; in_mb_md = md;
        {in_mb_q3_rden, in_mb_q2_rden, in_mb_q1_rden, in_mb_q0_rden} = rd;
    endtask

    // driver: called at a negedge, returns at the next negedge with outputs checked
    task automatic do_cycle(input logic wr, input logic [1:0] qid, input logic [7:0] md,
                            input logic [3:0] rd);
        drive(wr, qid, md, rd);
        model_step(wr, qid, md, rd);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    int wrap_idx;

    initial begin
        drive(1'b0, 2'd0, 8'd0, 4'd0);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_nempty", out_mb_q_nempty, 0);
        check("rst_full", out_mb_q_full, 0);
        check("rst_md_wr", out_mb_md_wr, 0);
        check("rst_drop_cnt", out_mb_drop_cnt, 0);

        // basic write / pop through q2
        do_cycle(1'b1, 2'd2, 8'h15, 4'b0000);
        check("q2_nempty", out_mb_q_nempty, 4'b0100);
        do_cycle(1'b0, 2'd0, 8'h00, 4'b0100);
        check("q2_md", out_mb_md, 8'h15);
        check("q2_md_wr", out_mb_md_wr, 1);
        check("q2_empty_after", out_mb_q_nempty, 0);

        // priority: q0 beats q3
        do_cycle(1'b1, 2'd0, 8'hA0, 4'b0000);
        do_cycle(1'b1, 2'd3, 8'hD3, 4'b0000);
        do_cycle(1'b0, 2'd0, 8'h00, 4'b1001);
        check("prio_md", out_mb_md, 8'hA0);
        check("prio_q3_left", out_mb_q_nempty, 4'b1000);
        do_cycle(1'b0, 2'd0, 8'h00, 4'b1000);
        check("prio_q3_md", out_mb_md, 8'hD3);

        // held rden drains three entries, then idles without underflow
        for (int i = 1; i <= 3; i++) do_cycle(1'b1, 2'd1, 8'(i), 4'b0000);
        for (int k = 0; k < 5; k++) begin
            do_cycle(1'b0, 2'd0, 8'h00, 4'b0010);
            check("held_md_wr", out_mb_md_wr, (k < 3) ? 1 : 0);
            if (k < 3) check("held_md", out_mb_md, k + 1);
        end
        check("held_empty", out_mb_q_nempty, 0);

        // full / drop on q0
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 2'd0, 8'(8'h40 + i), 4'b0000);
        check("full_16th", out_mb_q_full, 4'b0001);
        do_cycle(1'b1, 2'd0, 8'hEE, 4'b0000);
        check("drop_17th", out_mb_drop, 1);
        check("drop_cnt_1", out_mb_drop_cnt, 1);
        do_cycle(1'b1, 2'd0, 8'hEF, 4'b0001);
        check("drop_with_pop", out_mb_drop, 1);
        check("drop_cnt_2", out_mb_drop_cnt, 2);
        check("pop_on_full", out_mb_md, 8'h40);
        check("not_full_15", out_mb_q_full, 0);
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 2'd0, 8'h00, 4'b0001);
        check("q0_drained", out_mb_q_nempty, 0);

        // wrap-around on q3: write i while popping, output must be 0..39
        wrap_idx = 0;
        for (int i = 0; i <= 40; i++) begin
            do_cycle(i < 40, 2'd3, 8'(i), 4'b1000);
            if (out_mb_md_wr) begin
                check("wrap_seq", out_mb_md, wrap_idx);
                wrap_idx++;
            end
        end
        check("wrap_count", wrap_idx, 40);

        // random traffic, biased toward filling queues
        for (int n = 0; n < 600; n++) begin
            logic       wr;
            logic [3:0] rd;
            wr = ($urandom_range(0, 9) < 7);
            rd = ($urandom_range(0, 9) < 4) ? 4'($urandom_range(0, 15)) : 4'd0;
            do_cycle(wr, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), rd);
        end

        // async reset mid-stream with a pop in flight
        do_cycle(1'b1, 2'd1, 8'h77, 4'b0000);
        do_cycle(1'b1, 2'd2, 8'h78, 4'b0000);
        drive(1'b1, 2'd2, 8'h79, 4'b1111);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_md_wr", out_mb_md_wr, 0);
        check("arst_md", out_mb_md, 0);
        check("arst_nempty", out_mb_q_nempty, 0);
        check("arst_full", out_mb_q_full, 0);
        check("arst_drop", out_mb_drop, 0);
        check("arst_drop_cnt", out_mb_drop_cnt, 0);
        model_reset();
        drive(1'b0, 2'd0, 8'h00, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_cycle(1'b0, 2'd0, 8'h00, 4'b1111);
        check("post_rst_nempty", out_mb_q_nempty, 0);
        check("post_rst_drop_cnt", out_mb_drop_cnt, 0);
        check("post_rst_md_wr", out_mb_md_wr, 0);

        // final report
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
